fifo_arbiter: RTL

FIFO_ARBITER -- requirements
Module: fifo_arbiter

---
 rtl/fifo_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_arbiter.sv
// fifo_arbiter
//   Arbitrates a single FT245-style parallel FIFO between a receive path
//   (FIFO -> rx_data, e.g. keyboard bytes) and a transmit path
//   (tx_data -> FIFO, e.g. terminal bytes). RXF#/TXE# are resynchronized
//   and every bus cycle is timed by a 4-bit down-counter.
//
// Parameters
//   RD_CYCLES  : RD# low width in clocks (1-15)
//   WR_CYCLES  : WR high width in clocks (1-15)
//   GAP_CYCLES : minimum idle after a strobe; the gap states last GAP_CYCLES+2
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   fifo_rxf   : RXF#, low = FIFO has a byte to read
//   fifo_txe   : TXE#, low = FIFO has room for a byte
//   fifo_rd    : RD#, active-low read strobe
//   fifo_wr    : WR, active-high write strobe (FIFO latches on its fall)
//   fifo_data  : shared 7-bit bus, driven only in WR_SETUP/WR_STROBE/WR_HOLD
//   rx_data    : last byte read from the FIFO
//   rx_valid   : rx_data holds an unconsumed byte
//   rx_ack     : consumer takes rx_data (ignored while rx_valid=0)
//   tx_data    : byte offered for writing
//   tx_valid   : producer offers tx_data
//   tx_ready   : transmit holding register is empty
//   busy       : FSM is not in IDLE
//   dbg_state  : current FSM state encoding
//
// Handshakes: a byte moves on the rx side on any rising edge with
// rx_valid & rx_ack, and on the tx side on any rising edge with
// tx_valid & tx_ready. A valid, once raised by the DUT (rx_valid), holds
// its data stable until the transfer edge.

module fifo_arbiter #(
  parameter int RD_CYCLES  = 2,
  parameter int WR_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_rxf,
  input  logic       fifo_txe,
  output logic       fifo_rd,
  output logic       fifo_wr,
  inout  wire  [6:0] fifo_data,
  output logic [6:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic [6:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_STROBE = 3'd1,
    RD_GAP    = 3'd2,
    WR_SETUP  = 3'd3,
    WR_STROBE = 3'd4,
    WR_HOLD   = 3'd5,
    WR_GAP    = 3'd6
  } state_t;

  localparam logic [3:0] RD_LOAD  = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LOAD  = 4'(WR_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  // The gap lasts GAP_CYCLES+2 clocks; the counter covers GAP_CYCLES+1 of
  // them and this flag adds the final clock so the counter never needs a
  // fifth bit.
  logic       r_gap_tail;
  logic [3:0] w_load_val;

  logic       r_rxf_meta, r_rxf_s;
  logic       r_txe_meta, r_txe_s;
  logic       r_last_tx;      // 1 = last grant went to TX, so RX wins a tie
  logic       r_rd_n, r_wr, r_oe;
  logic [6:0] r_rx_data;
  logic       r_rx_valid;
  logic [6:0] r_tx_hold;
  logic       r_tx_full;

  logic       w_rx_elig, w_tx_elig;
  logic       w_grant_rx, w_grant_tx;
  logic       w_capture, w_tx_done;

  assign w_rx_elig = !r_rxf_s && !r_rx_valid;
  assign w_tx_elig = !r_txe_s && r_tx_full;

  always_comb begin
    w_next     = r_state;
    w_load_val = 4'd0;
    w_grant_rx = 1'b0;
    w_grant_tx = 1'b0;
    w_capture  = 1'b0;
    w_tx_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rx_elig && (!w_tx_elig || r_last_tx)) begin
          w_next     = RD_STROBE;
          w_load_val = RD_LOAD;
          w_grant_rx = 1'b1;
        end else if (w_tx_elig) begin
          w_next     = WR_SETUP;
          w_grant_tx = 1'b1;
        end
      end
      RD_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_next     = RD_GAP;
          w_load_val = GAP_LOAD;
          w_capture  = 1'b1;   // bus sampled on the edge ending the strobe
        end
      end
      RD_GAP: begin
        if (r_cnt == 4'd0 && r_gap_tail) w_next = IDLE;
      end
      WR_SETUP: begin
        w_next     = WR_STROBE;
        w_load_val = WR_LOAD;
      end
      WR_STROBE: begin
        if (r_cnt == 4'd0) w_next = WR_HOLD;
      end
      WR_HOLD: begin
        w_next     = WR_GAP;
        w_load_val = GAP_LOAD;
        w_tx_done  = 1'b1;
      end
      WR_GAP: begin
        if (r_cnt == 4'd0 && r_gap_tail) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_gap_tail <= 1'b0;
      r_rxf_meta <= 1'b1;
      r_rxf_s    <= 1'b1;
      r_txe_meta <= 1'b1;
      r_txe_s    <= 1'b1;
      r_last_tx  <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr       <= 1'b0;
      r_oe       <= 1'b0;
      r_rx_data  <= 7'd0;
      r_rx_valid <= 1'b0;
      r_tx_hold  <= 7'd0;
      r_tx_full  <= 1'b0;
    end else begin
      r_rxf_meta <= fifo_rxf;
      r_rxf_s    <= r_rxf_meta;
      r_txe_meta <= fifo_txe;
      r_txe_s    <= r_txe_meta;

      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt      <= w_load_val;
        r_gap_tail <= 1'b0;
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_gap_tail <= 1'b1;
      end

      if (w_grant_rx) r_last_tx <= 1'b0;
      if (w_grant_tx) r_last_tx <= 1'b1;

      // Strobes are registered from the next state so they are glitch-free.
      r_rd_n <= (w_next != RD_STROBE);
      r_wr   <= (w_next == WR_STROBE);
      r_oe   <= (w_next == WR_SETUP) || (w_next == WR_STROBE) ||
                (w_next == WR_HOLD);

      if (w_capture) begin
        r_rx_data  <= fifo_data;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ack) begin
        r_rx_valid <= 1'b0;
      end

      if (w_tx_done) begin
        r_tx_full <= 1'b0;
      end else if (tx_valid && !r_tx_full) begin
        r_tx_hold <= tx_data;
        r_tx_full <= 1'b1;
      end
    end
  end

  assign fifo_data = r_oe ? r_tx_hold : 7'bzzzzzzz;
  assign fifo_rd   = r_rd_n;
  assign fifo_wr   = r_wr;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_ready  = !r_tx_full;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule
